// File: rtl/sync_updown_counter_mod.sv
// -----------------------------------------------------------------------------
// sync_updown_counter_mod
//
// Purpose
//   Parametrised synchronous up/down counter. It counts over 0..MODULUS-1 and
//   provides count enable, synchronous parallel load with clamping, a
//   combinational terminal-count flag and a registered one-cycle wrap pulse.
//   It serves as a generic tick/index counter.
//
// Parameters
//   WIDTH    counter width in bits, 2..32
//   MODULUS  number of count states, 2..2**WIDTH (count range 0..MODULUS-1)
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset (q=0, wrap=0)
//   en        in   1      count enable; q holds when 0
//   up_down   in   1      1 = count up, 0 = count down
//   load      in   1      synchronous parallel load (overrides en)
//   load_val  in   WIDTH  value to load; values above MODULUS-1 are clamped
//   q         out  WIDTH  current count, registered
//   tc        out  1      terminal count, combinational
//   wrap      out  1      registered pulse for the cycle after a boundary event
//
// Build option
//   COUNTER_SATURATE_EN : when defined, the counter holds at a boundary
//   instead of wrapping. wrap then pulses on every edge where a count was
//   blocked. Without it the counter wraps modulo MODULUS.
// -----------------------------------------------------------------------------
module sync_updown_counter_mod #(
   parameter int unsigned     WIDTH   = 8,
   parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   // Elaboration-time legality checks on the configuration.
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("sync_updown_counter_mod: WIDTH=%0d outside 2..32", WIDTH);
   end
   if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("sync_updown_counter_mod: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end

   // Largest count value, held one bit wider than q so that MODULUS=2**WIDTH
   // needs no special case in the arithmetic below.
   localparam longint unsigned MAX_L   = MODULUS - 64'd1;
   localparam logic [WIDTH:0]  MAX_EXT = MAX_L[WIDTH:0];
   localparam logic [WIDTH-1:0] MAX_Q  = MAX_EXT[WIDTH-1:0];
   localparam logic [WIDTH:0]  ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   inc_ext;
   logic [WIDTH:0]   dec_ext;
   logic [WIDTH:0]   ld_ext;
   logic [WIDTH-1:0] ld_clamped;
   logic             at_max;
   logic             at_zero;

   assign cnt_ext = {1'b0, q_q};
   assign inc_ext = cnt_ext + ONE_EXT;
   assign dec_ext = cnt_ext - ONE_EXT;
   assign ld_ext  = {1'b0, load_val};
   assign at_max  = (cnt_ext == MAX_EXT);
   assign at_zero = (q_q == '0);

   // Load values beyond the count range are pinned to the top state.
   assign ld_clamped = (ld_ext > MAX_EXT) ? MAX_Q : load_val;

   // Next-state logic: load > count enable > hold. Reset is applied in the
   // register process and overrides everything here.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (load) begin
         q_d = ld_clamped;
      end else if (en) begin
         if (up_down) begin
            if (at_max) begin
`ifdef COUNTER_SATURATE_EN
               q_d    = q_q;
`else
               q_d    = '0;
`endif
               wrap_d = 1'b1;
            end else begin
               q_d = inc_ext[WIDTH-1:0];
            end
         end else begin
            if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
               q_d    = q_q;
`else
               q_d    = MAX_Q;
`endif
               wrap_d = 1'b1;
            end else begin
               q_d = dec_ext[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   // tc anticipates a boundary event on the next edge; it ignores load so it
   // reflects only the counting condition.
   assign tc   = en & ((up_down & at_max) | (~up_down & at_zero));
   assign q    = q_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_sync_updown_counter_mod
//
// Directed, table-driven bench for sync_updown_counter_mod with WIDTH=4.
// MODULUS=10 for the wrapping build, 16 when COUNTER_SATURATE_EN is defined.
// Each table row gives the inputs held across one rising edge and the q, wrap
// and tc values expected just after that edge (inputs still applied).
// -----------------------------------------------------------------------------
module tb_sync_updown_counter_mod;

   localparam int unsigned W = 4;
`ifdef COUNTER_SATURATE_EN
   localparam longint unsigned TB_MOD = 16;
`else
   localparam longint unsigned TB_MOD = 10;
`endif
   localparam logic [W-1:0] MAXV = W'(TB_MOD - 1);

   typedef struct {
      logic         rst;
      logic         en;
      logic         ud;
      logic         ld;
      logic [W-1:0] lv;
      logic [W-1:0] q;
      logic         tc;
      logic         wrap;
   } vec_t;

   vec_t vec[$];

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic         up_down = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q;
   logic         tc;
   logic         wrap;

   int compared = 0;
   int mismatched = 0;

   sync_updown_counter_mod #(
      .WIDTH   (W),
      .MODULUS (TB_MOD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_down  (up_down),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic e, input logic u, input logic l,
                      input int lv, input int eq, input logic etc, input logic ew);
      vec_t v;
      v.rst = r; v.en = e; v.ud = u; v.ld = l;
      v.lv = W'(lv); v.q = W'(eq); v.tc = etc; v.wrap = ew;
      vec.push_back(v);
   endtask

   task automatic check(input string nm, input int idx, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
      end
   endtask

   initial begin
      //   rst en ud ld lv   q  tc wr
`ifndef COUNTER_SATURATE_EN
      // Reset for two edges, then count up through the 9->0 wrap.
      add(1, 0, 1, 0, 0,   0, 0, 0);
      add(1, 0, 1, 0, 0,   0, 0, 0);
      add(0, 1, 1, 0, 0,   1, 0, 0);
      add(0, 1, 1, 0, 0,   2, 0, 0);
      add(0, 1, 1, 0, 0,   3, 0, 0);
      add(0, 1, 1, 0, 0,   4, 0, 0);
      add(0, 1, 1, 0, 0,   5, 0, 0);
      add(0, 1, 1, 0, 0,   6, 0, 0);
      add(0, 1, 1, 0, 0,   7, 0, 0);
      add(0, 1, 1, 0, 0,   8, 0, 0);
      add(0, 1, 1, 0, 0,   9, 1, 0);
      add(0, 1, 1, 0, 0,   0, 0, 1);
      add(0, 1, 1, 0, 0,   1, 0, 0);
      add(0, 1, 1, 0, 0,   2, 0, 0);
      // Back to 0, then count down through the 0->9 wrap twice.
      add(1, 0, 0, 0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 0,   9, 0, 1);
      add(0, 1, 0, 0, 0,   8, 0, 0);
      add(0, 1, 0, 0, 0,   7, 0, 0);
      add(0, 1, 0, 0, 0,   6, 0, 0);
      add(0, 1, 0, 0, 0,   5, 0, 0);
      add(0, 1, 0, 0, 0,   4, 0, 0);
      add(0, 1, 0, 0, 0,   3, 0, 0);
      add(0, 1, 0, 0, 0,   2, 0, 0);
      add(0, 1, 0, 0, 0,   1, 0, 0);
      add(0, 1, 0, 0, 0,   0, 1, 0);
      add(0, 1, 0, 0, 0,   9, 0, 1);
      // Load in range, then clamped loads; load from q=9 must not wrap.
      add(0, 1, 1, 1, 5,   5, 0, 0);
      add(0, 1, 1, 1, 13,  9, 1, 0);
      add(0, 1, 1, 1, 10,  9, 1, 0);
      add(0, 0, 1, 1, 15,  9, 0, 0);
      // Hold with en=0 at q=9, then enable and wrap.
      add(0, 0, 1, 0, 0,   9, 0, 0);
      add(0, 0, 1, 0, 0,   9, 0, 0);
      add(0, 0, 1, 0, 0,   9, 0, 0);
      add(0, 1, 1, 0, 0,   0, 0, 1);
      // Reset beats load and en; then toggle direction each edge.
      add(1, 1, 1, 1, 7,   0, 0, 0);
      add(0, 1, 1, 0, 0,   1, 0, 0);
      add(0, 1, 1, 0, 0,   2, 0, 0);
      add(0, 1, 1, 0, 0,   3, 0, 0);
      add(0, 1, 1, 0, 0,   4, 0, 0);
      add(0, 1, 1, 0, 0,   5, 0, 0);
      add(0, 1, 0, 0, 0,   4, 0, 0);
      add(0, 1, 1, 0, 0,   5, 0, 0);
      add(0, 1, 0, 0, 0,   4, 0, 0);
      // Reset on a would-be wrap edge suppresses the wrap pulse.
      add(0, 1, 1, 1, 9,   9, 1, 0);
      add(1, 1, 1, 0, 0,   0, 0, 0);
      add(0, 0, 1, 0, 0,   0, 0, 0);
`else
      // Saturating build, MODULUS=16: hold at 15 with wrap on blocked edges.
      add(1, 0, 1, 0, 0,   0, 0, 0);
      add(1, 0, 1, 0, 0,   0, 0, 0);
      add(0, 1, 1, 1, 14, 14, 0, 0);
      add(0, 1, 1, 0, 0,  15, 1, 0);
      add(0, 1, 1, 0, 0,  15, 1, 1);
      add(0, 1, 1, 0, 0,  15, 1, 1);
      add(0, 1, 0, 0, 0,  14, 0, 0);
      add(0, 1, 0, 0, 0,  13, 0, 0);
      // Down at 0 stays at 0 with a wrap pulse each blocked edge.
      add(1, 0, 0, 0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 0,   0, 1, 1);
      add(0, 1, 0, 0, 0,   0, 1, 1);
      add(0, 1, 1, 0, 0,   1, 0, 0);
      add(0, 0, 1, 0, 0,   1, 0, 0);
      // Reset during a blocked edge clears wrap.
      add(0, 1, 1, 1, 15, 15, 1, 0);
      add(1, 1, 1, 0, 0,   0, 0, 0);
`endif

      for (int i = 0; i < vec.size(); i++) begin
         @(negedge clk);
         reset    = vec[i].rst;
         en       = vec[i].en;
         up_down  = vec[i].ud;
         load     = vec[i].ld;
         load_val = vec[i].lv;
         @(posedge clk);
         #1;
         check("q",    i, int'(q),    int'(vec[i].q));
         check("wrap", i, int'(wrap), int'(vec[i].wrap));
         check("tc",   i, int'(tc),   int'(vec[i].tc));
      end

      // tc is combinational: it must follow en/up_down with no clock edge.
      @(negedge clk);
      reset = 1'b1; en = 1'b0; up_down = 1'b0; load = 1'b0; load_val = '0;
      @(posedge clk);
      #1;
      check("seq_reset_q", 0, int'(q), 0);
      @(negedge clk);
      reset = 1'b0; en = 1'b1; up_down = 1'b0;
      #1;
      check("seq_tc_down_at0", 0, int'(tc), 1);
      up_down = 1'b1;
      #1;
      check("seq_tc_up_at0", 0, int'(tc), 0);
      en = 1'b0; load = 1'b1; load_val = MAXV;
      @(posedge clk);
      #1;
      check("seq_load_max_q", 0, int'(q), int'(MAXV));
      check("seq_tc_en0_atmax", 0, int'(tc), 0);
      @(negedge clk);
      load = 1'b0; en = 1'b1; up_down = 1'b1;
      #1;
      check("seq_tc_up_atmax", 0, int'(tc), 1);
      up_down = 1'b0;
      #1;
      check("seq_tc_down_atmax", 0, int'(tc), 0);
      // Direction changed before the edge: counts down, no wrap.
      @(posedge clk);
      #1;
      check("seq_dir_change_q", 0, int'(q), int'(MAXV) - 1);
      check("seq_dir_change_wrap", 0, int'(wrap), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
